// File: rtl/dig_ota_pkg.sv
// Shared types and helpers for the clocked digital OTA channel array.
// Optional per-channel reversal statistics are enabled with DIG_OTA_STATS_EN.
package dig_ota_pkg;

  typedef enum logic [1:0] {
    HIZ   = 2'd0,
    SRC   = 2'd1,
    SNK   = 2'd2,
    BREAK = 2'd3
  } ota_state_t;

  localparam logic [7:0] STAT_MAX = 8'hFF;

  // Comparator decode: only a clean differential pair drives the pin.
  function automatic ota_state_t want_of(input logic vip, input logic vin);
    case ({vip, vin})
      2'b10:   return SRC;
      2'b01:   return SNK;
      default: return HIZ;
    endcase
  endfunction

endpackage

// File: rtl/dig_ota_chan.sv
// One OTA channel: input synchroniser, debounce, drive FSM with break-before-make.
// With DIG_OTA_STATS_EN defined it also counts reversals (BREAK entries).
module dig_ota_chan
  import dig_ota_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       vip,
  input  logic       vin,
`ifdef DIG_OTA_STATS_EN
  input  logic       stat_clr,
  output logic [7:0] stat_cnt,
`endif
  output logic [1:0] state,
  output logic       deb_busy
);

  localparam int CNT_W = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'((DEB_CYCLES > 0) ? DEB_CYCLES - 1 : 0);

  logic [SYNC_STAGES-1:0] sync_p, sync_n;
  ota_state_t             state_q, state_d, target_q, target_d, prev_q, prev_d, want;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   enter_break, stable, reached, reversal;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p <= '0;
      sync_n <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], vip};
      sync_n <= {sync_n[SYNC_STAGES-2:0], vin};
    end
  end

  assign want     = want_of(sync_p[SYNC_STAGES-1], sync_n[SYNC_STAGES-1]);
  assign stable   = (DEB_CYCLES == 0) || (want == prev_q);
  assign reached  = (DEB_CYCLES == 0) || (cnt_q == DEB_LAST);
  assign reversal = (state_q == SRC && want == SNK) || (state_q == SNK && want == SRC);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    prev_d      = want;
    enter_break = 1'b0;
    if (!ena) begin
      state_d = HIZ;
      cnt_d   = '0;
      prev_d  = HIZ;
    end else if (state_q == BREAK) begin
      cnt_d   = '0;
      state_d = (want == target_q) ? target_q : HIZ;
    end else if (want == state_q || !stable) begin
      cnt_d = '0;
    end else if (reached) begin
      cnt_d = '0;
      if (reversal) begin
        state_d     = BREAK;
        target_d    = want;
        enter_break = 1'b1;
      end else begin
        state_d = want;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= HIZ;
      target_q <= HIZ;
      prev_q   <= HIZ;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

  assign state    = state_q;
  assign deb_busy = (cnt_q != '0);

`ifdef DIG_OTA_STATS_EN
  logic [7:0] rev_cnt;

  // Clear has priority over a coinciding reversal; the counter saturates.
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr)
      rev_cnt <= '0;
    else if (enter_break && rev_cnt != STAT_MAX)
      rev_cnt <= rev_cnt + 8'd1;
  end

  assign stat_cnt = rev_cnt;
`endif

endmodule

// File: rtl/dig_ota_array.sv
// N-channel clocked digital OTA: per-channel FSMs plus shared gm PWM and registered drive.
// Define DIG_OTA_STATS_EN to add the stat_sel/stat_clr/stat_cnt reversal statistics port.
module dig_ota_array
  import dig_ota_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 3,
  parameter int GM_W        = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [N_CH-1:0]          vip,
  input  logic [N_CH-1:0]          vin,
  input  logic [GM_W-1:0]          gm,
`ifdef DIG_OTA_STATS_EN
  input  logic [$clog2(N_CH)-1:0]  stat_sel,
  input  logic                     stat_clr,
  output logic [7:0]               stat_cnt,
`endif
  output logic [N_CH-1:0]          out_val,
  output logic [N_CH-1:0]          out_oe,
  output logic [N_CH-1:0]          st_busy
);

  logic [GM_W-1:0] pwm_cnt;
  logic            pulse;
  logic [1:0]      chan_state [N_CH];
  logic [N_CH-1:0] chan_deb, oe_d, val_d, busy_d;
`ifdef DIG_OTA_STATS_EN
  logic [7:0]      chan_stat [N_CH];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || !ena)
      pwm_cnt <= '0;
    else
      pwm_cnt <= pwm_cnt + GM_W'(1);
  end

  // Full-scale gm is a constant drive rather than 15/16 duty.
  assign pulse = (gm == '1) || (pwm_cnt < gm);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    dig_ota_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .vip     (vip[g]),
      .vin     (vin[g]),
`ifdef DIG_OTA_STATS_EN
      .stat_clr(stat_clr),
      .stat_cnt(chan_stat[g]),
`endif
      .state   (chan_state[g]),
      .deb_busy(chan_deb[g])
    );
  end

  always_comb begin
    oe_d   = '0;
    val_d  = '0;
    busy_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      oe_d[i]   = ena && pulse && (chan_state[i] == SRC || chan_state[i] == SNK);
      val_d[i]  = oe_d[i] && (chan_state[i] == SRC);
      busy_d[i] = chan_deb[i] || (chan_state[i] == BREAK);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_oe  <= '0;
      out_val <= '0;
      st_busy <= '0;
    end else begin
      out_oe  <= oe_d;
      out_val <= val_d;
      st_busy <= busy_d;
    end
  end

`ifdef DIG_OTA_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr)
      stat_cnt <= '0;
    else
      stat_cnt <= chan_stat[stat_sel];
  end
`endif

endmodule

// File: tb/tb_dig_ota_array.sv
// Self-checking bench for dig_ota_array: timed expectations go into a scoreboard queue and
// are compared on the falling edge they fall due. Reversal statistics run with DIG_OTA_STATS_EN.
module tb_dig_ota_array;

  localparam int SIG_OE = 0, SIG_VAL = 1, SIG_BUSY = 2, SIG_STAT = 3;

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [3:0] vip, vin, gm;
  logic [3:0] out_val, out_oe, st_busy;
`ifdef DIG_OTA_STATS_EN
  logic [1:0] stat_sel;
  logic       stat_clr;
  logic [7:0] stat_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    string      tag;
    int         sig;
    logic [7:0] mask;
    logic [7:0] exp;
  } exp_t;
  exp_t sb[$];

  dig_ota_array dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .vip     (vip),
    .vin     (vin),
    .gm      (gm),
`ifdef DIG_OTA_STATS_EN
    .stat_sel(stat_sel),
    .stat_clr(stat_clr),
    .stat_cnt(stat_cnt),
`endif
    .out_val (out_val),
    .out_oe  (out_oe),
    .st_busy (st_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] sample(input int sig);
    case (sig)
      SIG_OE:   return {4'b0, out_oe};
      SIG_VAL:  return {4'b0, out_val};
      SIG_BUSY: return {4'b0, st_busy};
`ifdef DIG_OTA_STATS_EN
      SIG_STAT: return stat_cnt;
`endif
      default:  return 8'h00;
    endcase
  endfunction

  task automatic expect_at(input int dly, input string tag, input int sig,
                           input logic [7:0] mask, input logic [7:0] exp);
    exp_t e;
    e.due = cyc + dly; e.tag = tag; e.sig = sig; e.mask = mask; e.exp = exp;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, int'(sample(sb[i].sig) & sb[i].mask), int'(sb[i].exp));
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_oe(input int bit_i, output int hits);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (out_oe[bit_i]) hits++;
    end
  endtask

  initial begin
    int hits, viol;
    logic prev_oe, prev_val;
    rst_n = 1'b0; ena = 1'b1; gm = 4'hF; vip = 4'hF; vin = 4'h0;
`ifdef DIG_OTA_STATS_EN
    stat_sel = 2'd3; stat_clr = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_oe", int'(out_oe), 0);
      check("rst_val", int'(out_val), 0);
      check("rst_busy", int'(st_busy), 0);
    end
    rst_n = 1'b1; vip = 4'h0;
    tick(4);

    // ch0 HIZ -> SRC: output appears 7 edges after the input edge
    vip = 4'b0001;
    expect_at(6, "deb_early_oe", SIG_OE, 8'h1, 8'h0);
    expect_at(7, "deb_oe", SIG_OE, 8'h1, 8'h1);
    expect_at(7, "deb_val", SIG_VAL, 8'h1, 8'h1);
    expect_at(5, "deb_busy", SIG_BUSY, 8'h1, 8'h1);
    expect_at(7, "deb_busy_end", SIG_BUSY, 8'h1, 8'h0);
    tick(10);

    // 2-cycle glitch on ch1 never makes it through the debounce
    vip = 4'b0011;
    expect_at(5, "glitch_busy", SIG_BUSY, 8'h2, 8'h2);
    expect_at(6, "glitch_busy_end", SIG_BUSY, 8'h2, 8'h0);
    expect_at(8, "glitch_oe", SIG_OE, 8'h2, 8'h0);
    tick(2);
    vip = 4'b0001;
    tick(8);

    // ch1 SRC then reversal to SNK through a single BREAK cycle
    vip = 4'b0011;
    tick(10);
    vip = 4'b0001; vin = 4'b0010;
    expect_at(6, "rev_pre_oe", SIG_OE, 8'h2, 8'h2);
    expect_at(6, "rev_pre_val", SIG_VAL, 8'h2, 8'h2);
    expect_at(7, "rev_break_oe", SIG_OE, 8'h2, 8'h0);
    expect_at(7, "rev_break_busy", SIG_BUSY, 8'h2, 8'h2);
    expect_at(8, "rev_snk_oe", SIG_OE, 8'h2, 8'h2);
    expect_at(8, "rev_snk_val", SIG_VAL, 8'h2, 8'h0);
    expect_at(8, "rev_snk_busy", SIG_BUSY, 8'h2, 8'h0);
    expect_at(8, "rev_ch0_oe", SIG_OE, 8'h1, 8'h1);
    viol = 0; prev_oe = out_oe[1]; prev_val = out_val[1];
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (prev_oe && out_oe[1] && prev_val != out_val[1]) viol++;
      prev_oe = out_oe[1]; prev_val = out_val[1];
    end
    check("rev_no_direct_flip", viol, 0);

    // PWM duty on ch0 (SRC) and ch1 (SNK)
    gm = 4'd4; tick(2);
    count_oe(0, hits); check("pwm4_ch0", hits, 4);
    count_oe(1, hits); check("pwm4_ch1", hits, 4);
    gm = 4'd0; tick(2);
    count_oe(0, hits); check("pwm0_ch0", hits, 0);
    gm = 4'hF; tick(2);
    count_oe(0, hits); check("pwmF_ch0", hits, 16);

    // ch2 to SNK, then disable and re-enable
    vin = 4'b0110;
    tick(10);
    check("en_ch2_oe", int'(out_oe[2]), 1);
    check("en_ch2_val", int'(out_val[2]), 0);
    ena = 1'b0;
    expect_at(1, "dis_oe", SIG_OE, 8'hF, 8'h0);
    tick(4);
    ena = 1'b1;
    expect_at(4, "reen_early_oe", SIG_OE, 8'h4, 8'h0);
    expect_at(5, "reen_oe", SIG_OE, 8'h4, 8'h4);
    tick(7);

    // Reset in the middle of ch3 debounce
    vip = 4'b1001;
    expect_at(5, "mid_busy", SIG_BUSY, 8'h8, 8'h8);
    tick(5);
    rst_n = 1'b0;
    expect_at(1, "mid_rst_oe", SIG_OE, 8'hF, 8'h0);
    expect_at(1, "mid_rst_val", SIG_VAL, 8'hF, 8'h0);
    expect_at(1, "mid_rst_busy", SIG_BUSY, 8'hF, 8'h0);
    tick(2);
    rst_n = 1'b1; vip = 4'h0; vin = 4'h0;
    expect_at(2, "post_rst_busy", SIG_BUSY, 8'hF, 8'h0);
    tick(8);

`ifdef DIG_OTA_STATS_EN
    // 300 reversals on ch3 saturate its counter at 255
    stat_sel = 2'd3;
    for (int k = 0; k <= 300; k++) begin
      if (k % 2 == 0) begin vip = 4'b1000; vin = 4'b0000; end
      else            begin vip = 4'b0000; vin = 4'b1000; end
      tick(8);
      if (k == 10) check("stat_10", int'(stat_cnt), 10);
    end
    check("stat_sat", int'(stat_cnt), 255);
    stat_sel = 2'd0; tick(2);
    check("stat_sel0", int'(stat_cnt), 0);
    stat_sel = 2'd3; tick(2);
    stat_clr = 1'b1; tick(1);
    stat_clr = 1'b0;
    check("stat_clr", int'(stat_cnt), 0);
    tick(1);
    check("stat_clr_hold", int'(stat_cnt), 0);
    vip = 4'h0; vin = 4'h0;
`endif

    for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
